uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter slice.
//   - UART_DATA_BITS, UART_START_BIT, UART_STOP_BIT line-level constants
//   - uart_tx_state_t and its state encodings
//   - even_parity() helper
// The PARITY state encoding only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef logic [2:0] uart_tx_state_t;

    localparam uart_tx_state_t ST_IDLE   = 3'd0;
    localparam uart_tx_state_t ST_START  = 3'd1;
    localparam uart_tx_state_t ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam uart_tx_state_t ST_PARITY = 3'd3;
`endif
    localparam uart_tx_state_t ST_STOP   = 3'd4;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial-side signals of uart_tx.
//   i_valid    : upstream byte on i_data is offered
//   i_data     : byte to transmit
//   o_ready    : transmitter accepts i_data this cycle when i_valid is high
//   o_get_next : one-cycle pulse on the acceptance cycle
//   o_tx       : serial line, idle high
//   o_busy     : high from first start-bit cycle to last stop-bit cycle
// master = byte source side, slave = transmitter side.
interface uart_tx_if;

    logic                                i_valid;
    logic [uart_pkg::UART_DATA_BITS-1:0] i_data;
    logic                                o_ready;
    logic                                o_get_next;
    logic                                o_tx;
    logic                                o_busy;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_get_next, o_tx, o_busy
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_get_next, o_tx, o_busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit cycle counter for uart_tx.
//   i_clk     : clock, rising edge
//   i_rst_n   : synchronous active-low reset
//   i_restart : force the counter back to 0 (held while idle / on a new frame)
//   o_tick    : high on the last cycle of each bit period
// Parameter CLKS_PER_BAUD (2..65535): clock cycles per serial bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BAUD = 104
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BAUD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == CNT_LAST);

    // Wrap to 0 on every bit boundary so bit lengths never accumulate error.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : uart_tx_if.slave (i_valid/i_data in, o_ready/o_get_next/
//             o_tx/o_busy out)
// Parameter CLKS_PER_BAUD (2..65535): clock cycles per serial bit.
// Macro UART_TX_PARITY_EN: adds an even-parity bit after data bit 7.
// A new byte may be accepted in the last stop-bit cycle, so streamed bytes
// go out back to back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 104
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    uart_tx_if.slave bus
);

    localparam int                BCW      = $clog2(UART_DATA_BITS);
    localparam logic [BCW-1:0]    BIT_LAST = BCW'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]            bitcnt_q, bitcnt_d;
    logic                      rdy_en_q, rdy_en_d;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic tick;
    logic ready;
    logic accept;
    logic restart;
    logic tx;

    // Counter sits at 0 while idle, so a new frame always starts a full bit.
    assign restart = (state_q == ST_IDLE) || accept;

    uart_baud_tick #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_baud (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_restart(restart),
        .o_tick   (tick)
    );

    // rdy_en_q keeps o_ready low until the first edge that sees reset released.
    assign ready  = rdy_en_q && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_STOP) && tick));
    assign accept = bus.i_valid && ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rdy_en_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    // LSB first; fill with stop level so shreg ends at all-ones.
                    shreg_d = {UART_STOP_BIT, shreg_q[UART_DATA_BITS-1:1]};
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
`else
                        state_d  = ST_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance happens from IDLE or the last STOP cycle and overrides
        // the normal step, chaining straight into the next start bit.
        if (accept) begin
            state_d  = ST_START;
            shreg_d  = bus.i_data;
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            par_d    = even_parity(bus.i_data);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '1;
            bitcnt_q <= '0;
            rdy_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            rdy_en_q <= rdy_en_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        tx = UART_STOP_BIT;
        case (state_q)
            ST_START:  tx = UART_START_BIT;
            ST_DATA:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = par_q;
`endif
            default:   tx = UART_STOP_BIT;
        endcase
    end

    assign bus.o_tx       = tx;
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_ready    = ready;
    assign bus.o_get_next = accept;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Instance A uses CLKS_PER_BAUD=4, instance B uses 104. Accepted bytes are
// queued when o_get_next fires; a line monitor captures each frame cycle by
// cycle, pops the expected byte and compares the whole frame.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int CB_A = 4;
    localparam int CB_B = 104;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   gn_a   = 0;
    int   gn_b   = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         starts_a[$];
    int         starts_b[$];
    logic [7:0] sbuf[14];

    uart_tx_if ifa();
    uart_tx_if ifb();

    uart_tx #(.CLKS_PER_BAUD(CB_A)) u_dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (ifa)
    );

    uart_tx #(.CLKS_PER_BAUD(CB_B)) u_dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int s);
        return (s != 0) ? ifb.o_tx : ifa.o_tx;
    endfunction

    function automatic logic busy_of(input int s);
        return (s != 0) ? ifb.o_busy : ifa.o_busy;
    endfunction

    // Expected line levels, bit 0 = start bit.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Capture one frame starting at the current sample point (start bit seen).
    task automatic mon(input int s, input int cb);
        logic [FB-1:0] lvl;
        logic [7:0]    eb;
        logic          ok;
        logic          ab;
        int            n;
        lvl = '1; ok = 1'b1; ab = 1'b0; n = 0;
        if (s != 0) starts_b.push_back(cyc); else starts_a.push_back(cyc);
        while (n < FB * cb && !ab) begin
            if (n > 0) begin @(negedge clk); #2; end
            if (!rst_n) begin
                ab = 1'b1;
            end else begin
                if (n % cb == 0) lvl[n / cb] = tx_of(s);
                else if (tx_of(s) !== lvl[n / cb]) ok = 1'b0;
                if (busy_of(s) !== 1'b1) ok = 1'b0;
            end
            n++;
        end
        if (((s != 0) ? qb.size() : qa.size()) == 0) begin
            chk("sb_unexpected_frame", 32'd1, 32'd0);
        end else begin
            if (s != 0) eb = qb.pop_front(); else eb = qa.pop_front();
            if (!ab) begin
                chk((s != 0) ? "frame_b" : "frame_a", 32'(lvl), 32'(frame_of(eb)));
                chk((s != 0) ? "bit_time_b" : "bit_time_a", 32'(ok), 32'd1);
            end
        end
    endtask

    initial forever begin
        @(negedge clk); #2;
        if (rst_n && ifa.o_tx === 1'b0) mon(0, CB_A);
    end

    initial forever begin
        @(negedge clk); #2;
        if (rst_n && ifb.o_tx === 1'b0) mon(1, CB_B);
    end

    initial forever begin
        @(negedge clk); #2;
        if (ifa.o_get_next === 1'b1) begin qa.push_back(ifa.i_data); gn_a++; end
        if (ifb.o_get_next === 1'b1) begin qb.push_back(ifb.i_data); gn_b++; end
    end

    // Offer sbuf[0..n-1] with valid held high; call at a falling edge.
    task automatic stream(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            int   t;
            logic g;
            if (s != 0) begin ifb.i_data = sbuf[i]; ifb.i_valid = 1'b1; end
            else        begin ifa.i_data = sbuf[i]; ifa.i_valid = 1'b1; end
            t = 0; g = 1'b0;
            while (!g && t < 3000) begin
                #1;
                g = (s != 0) ? ifb.o_get_next : ifa.o_get_next;
                @(negedge clk);
                t++;
            end
            if (!g) chk("accept_timeout", 32'd0, 32'd1);
        end
        if (s != 0) ifb.i_valid = 1'b0; else ifa.i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int t;
        t = 0;
        do begin @(negedge clk); #1; t++; end while (busy_of(s) && t < 20000);
        if (busy_of(s)) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int   nb, nr, t, g0;
        logic ok;
        ifa.i_valid = 1'b0; ifa.i_data = 8'h00;
        ifb.i_valid = 1'b0; ifb.i_data = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx",   32'(ifa.o_tx),       32'd1);
        chk("rst_busy", 32'(ifa.o_busy),     32'd0);
        chk("rst_rdy",  32'(ifa.o_ready),    32'd0);
        chk("rst_gn",   32'(ifa.o_get_next), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rdy_pre",  32'(ifa.o_ready), 32'd0);
        @(negedge clk); #1;
        chk("rdy_rise", 32'(ifa.o_ready), 32'd1);

        // idle with valid low
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (ifa.o_tx !== 1'b1 || ifa.o_busy !== 1'b0) ok = 1'b0;
        end
        chk("idle_hold", 32'(ok), 32'd1);

        // single byte 0x48, one-cycle valid
        @(negedge clk); ifa.i_data = 8'h48; ifa.i_valid = 1'b1; #1;
        chk("gn_pulse", 32'(ifa.o_get_next), 32'd1);
        chk("rdy_idle", 32'(ifa.o_ready),    32'd1);
        @(negedge clk); ifa.i_valid = 1'b0; #1;
        chk("lat1_tx",   32'(ifa.o_tx),   32'd0);
        chk("lat1_busy", 32'(ifa.o_busy), 32'd1);
        nb = 0; nr = 0; t = 0;
        while (ifa.o_busy === 1'b1 && t < 400) begin
            nb++;
            if (ifa.o_ready !== 1'b1) nr++;
            @(negedge clk); #1; t++;
        end
        chk("busy_len", 32'(nb), 32'(FB * CB_A));
        chk("rdy_low",  32'(nr), 32'(FB * CB_A - 1));

        // back-to-back 0x48, 0x65
        @(negedge clk); sbuf[0] = 8'h48; sbuf[1] = 8'h65;
        stream(0, 2); wait_idle(0);
        chk("b2b_gap", 32'(starts_a[starts_a.size()-1] - starts_a[starts_a.size()-2]),
            32'(FB * CB_A));

        // reset during data bit 3 of 0x55
        @(negedge clk); sbuf[0] = 8'h55;
        stream(0, 1);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("abort_tx",   32'(ifa.o_tx),    32'd1);
        chk("abort_busy", 32'(ifa.o_busy),  32'd0);
        chk("abort_rdy",  32'(ifa.o_ready), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rdy_pre2",  32'(ifa.o_ready), 32'd0);
        @(negedge clk); #1;
        chk("rdy_rise2", 32'(ifa.o_ready), 32'd1);
        chk("post_rst_tx", 32'(ifa.o_tx), 32'd1);
        @(negedge clk); sbuf[0] = 8'h3C;
        stream(0, 1); wait_idle(0);

        // i_data scrambled mid-frame with valid low
        g0 = gn_a;
        @(negedge clk); sbuf[0] = 8'hA5;
        stream(0, 1);
        t = 0;
        while (ifa.o_busy === 1'b1 && t < 400) begin
            ifa.i_data = 8'($urandom);
            @(negedge clk); #1; t++;
        end
        chk("gn_once", 32'(gn_a - g0), 32'd1);

        // parity patterns and all-zero / all-one bytes
        @(negedge clk);
        sbuf[0] = 8'h07; sbuf[1] = 8'h48; sbuf[2] = 8'h00; sbuf[3] = 8'hFF;
        stream(0, 4); wait_idle(0);
        chk("frame_period", 32'(starts_a[starts_a.size()-1] - starts_a[starts_a.size()-2]),
            32'(FB * CB_A));

        // 14 streamed bytes at CLKS_PER_BAUD=104
        @(negedge clk);
        for (int i = 0; i < 14; i++) sbuf[i] = 8'($urandom);
        stream(1, 14); wait_idle(1);
        chk("b_frames", 32'(starts_b.size()), 32'd14);
        chk("b_total",  32'(starts_b[13] - starts_b[0]), 32'(13 * FB * CB_B));
        chk("b_gn",     32'(gn_b), 32'd14);

        chk("sb_drain_a", 32'(qa.size()), 32'd0);
        chk("sb_drain_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
